// File: rtl/tft_in_pio_pkg.sv
// tft_in_pio_pkg
// Shared constants for the tft_in_pio input port: Avalon register
// addresses, edge-type encodings and the debounce counter width helper.
package tft_in_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_ANY  = 2;

    // Counter must hold 0..cycles; keep at least one bit so the debounce
    // bypass configuration still elaborates to a legal vector.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/tft_in_debounce.sv
// tft_in_debounce
// One input bit: 2-flop synchronizer, debounce counter, stable value S and
// its delayed copy S_d, plus the selected edge strobe.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   pin_i        : asynchronous board input
//   data_o       : debounced stable value S
//   edge_o       : one-cycle strobe when S changes in the selected direction
module tft_in_debounce
    import tft_in_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter int   EDGE_TYPE       = EDGE_FALL,
    parameter logic RESET_BIT       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic data_o,
    output logic edge_o
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          meta_q;
    logic          sync_q;
    logic          stable_q;
    logic          stable_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (DEBOUNCE_CYCLES == 0) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Counter never runs past CNT_MAX: accepting the change clears it.
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q   <= RESET_BIT;
            sync_q   <= RESET_BIT;
            stable_q <= RESET_BIT;
            prev_q   <= RESET_BIT;
            cnt_q    <= '0;
        end else begin
            meta_q   <= pin_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_o = ~prev_q & stable_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_o = prev_q ^ stable_q;
        end else begin
            edge_o = prev_q & ~stable_q;
        end
    end

    assign data_o = stable_q;

endmodule

// File: rtl/tft_in_pio.sv
// tft_in_pio
// Avalon-MM slave input port with per-bit debounce, edge capture and a
// maskable level interrupt. Zero-wait-state reads and writes.
// Ports:
//   clk, reset_n           : system clock, async active-low reset
//   address, chipselect,
//   write_n, writedata     : Avalon slave write side
//   readdata               : combinational read data selected by address
//   in_port                : asynchronous board inputs
//   irq                    : level interrupt, |(EDGE_CAPTURE & IRQ_MASK)
module tft_in_pio
    import tft_in_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               EDGE_TYPE       = EDGE_FALL,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_vec;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] clr_vec;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tft_in_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_TYPE       (EDGE_TYPE),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .pin_i   (in_port[i]),
            .data_o  (data_vec[i]),
            .edge_o  (edge_vec[i])
        );
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        mask_d  = mask_q;
        clr_vec = '0;
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = writedata;
        end
        if (wr_en && (address == ADDR_EDGE)) begin
            clr_vec = writedata;
        end
        // Set is ORed after the clear so a coincident edge keeps the bit.
        cap_d = (cap_q & ~clr_vec) | edge_vec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    assign irq = |(cap_q & mask_q);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = data_vec;
            ADDR_MASK: readdata = mask_q;
            ADDR_EDGE: readdata = cap_q;
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_tft_in_pio.sv
module tb_tft_in_pio;
    import tft_in_pio_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: D=4, falling edge.  Instance B: D=0, any edge.
    logic       rst_a, cs_a, wn_a, irq_a;
    logic [1:0] addr_a;
    logic [3:0] wd_a, rd_a, in_a;
    logic       rst_b, cs_b, wn_b, irq_b;
    logic [1:0] addr_b;
    logic [3:0] wd_b, rd_b, in_b;

    int n_vec = 0;
    int n_err = 0;

    tft_in_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_FALL)) dut_a (
        .clk(clk), .reset_n(rst_a), .address(addr_a), .chipselect(cs_a),
        .write_n(wn_a), .writedata(wd_a), .readdata(rd_a), .in_port(in_a),
        .irq(irq_a)
    );

    tft_in_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(EDGE_ANY)) dut_b (
        .clk(clk), .reset_n(rst_b), .address(addr_b), .chipselect(cs_b),
        .write_n(wn_b), .writedata(wd_b), .readdata(rd_b), .in_port(in_b),
        .irq(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rd(input bit b, input logic [1:0] a, output logic [3:0] v);
        if (!b) begin
            addr_a = a;
            #1 v = rd_a;
        end else begin
            addr_b = a;
            #1 v = rd_b;
        end
    endtask

    task automatic chk_reg(input bit b, input string tag, input logic [1:0] a, input logic [3:0] exp);
        logic [3:0] v;
        rd(b, a, v);
        chk(tag, {28'd0, v}, {28'd0, exp});
    endtask

    task automatic wr(input bit b, input logic [1:0] a, input logic [3:0] d);
        if (!b) begin
            addr_a = a; wd_a = d; cs_a = 1'b1; wn_a = 1'b0;
        end else begin
            addr_b = a; wd_b = d; cs_b = 1'b1; wn_b = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cs_a = 1'b0; wn_a = 1'b1;
        cs_b = 1'b0; wn_b = 1'b1;
    endtask

    initial begin
        logic [3:0] v;
        rst_a = 1'b0; cs_a = 1'b0; wn_a = 1'b1; addr_a = 2'd0; wd_a = 4'h0; in_a = 4'hF;
        rst_b = 1'b0; cs_b = 1'b0; wn_b = 1'b1; addr_b = 2'd0; wd_b = 4'h0; in_b = 4'hF;
        @(negedge clk);

        // Reset state
        chk_reg(0, "rst_data", ADDR_DATA, 4'hF);
        chk_reg(0, "rst_cap", ADDR_EDGE, 4'h0);
        chk_reg(0, "rst_mask", ADDR_MASK, 4'h0);
        chk("rst_irq", {31'd0, irq_a}, 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(4);
        chk_reg(0, "rel_cap", ADDR_EDGE, 4'h0);
        chk_reg(0, "rsvd", ADDR_RSVD, 4'h0);
        wr(0, ADDR_RSVD, 4'hF);
        chk_reg(0, "rsvd_wr", ADDR_RSVD, 4'h0);
        wr(0, ADDR_DATA, 4'h0);
        chk_reg(0, "data_wr", ADDR_DATA, 4'hF);

        // Falling edge timing, D=4: DATA at edge 6, capture/irq at edge 7
        wr(0, ADDR_MASK, 4'h1);
        chk_reg(0, "mask_rb", ADDR_MASK, 4'h1);
        in_a = 4'hE;
        for (int k = 0; k < 9; k++) begin
            step(1);
            rd(0, ADDR_DATA, v);
            chk($sformatf("fall_data_e%0d", k), {31'd0, v[0]}, (k >= 6) ? 32'd0 : 32'd1);
            chk_reg(0, $sformatf("fall_cap_e%0d", k), ADDR_EDGE, (k >= 7) ? 4'h1 : 4'h0);
            chk($sformatf("fall_irq_e%0d", k), {31'd0, irq_a}, (k >= 7) ? 32'd1 : 32'd0);
        end
        wr(0, ADDR_EDGE, 4'h1);
        chk("w1c_irq", {31'd0, irq_a}, 32'd0);
        chk_reg(0, "w1c_cap", ADDR_EDGE, 4'h0);

        // Glitch on bit1 shorter than the debounce window
        in_a = 4'hC;
        step(3);
        in_a = 4'hE;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk_reg(0, $sformatf("glitch_data_%0d", k), ADDR_DATA, 4'hE);
        end
        chk_reg(0, "glitch_cap", ADDR_EDGE, 4'h0);

        // Pulse long enough to be accepted: one falling capture only
        in_a = 4'hC;
        step(5);
        in_a = 4'hE;
        step(12);
        chk_reg(0, "pulse_cap", ADDR_EDGE, 4'h2);
        chk_reg(0, "pulse_data", ADDR_DATA, 4'hE);
        chk("pulse_irq", {31'd0, irq_a}, 32'd0);
        wr(0, ADDR_EDGE, 4'h2);
        chk_reg(0, "pulse_clr", ADDR_EDGE, 4'h0);

        // Masked capture, then unmask raises irq the same cycle
        wr(0, ADDR_MASK, 4'h0);
        in_a = 4'hA;
        step(10);
        chk_reg(0, "mask0_cap", ADDR_EDGE, 4'h4);
        chk("mask0_irq", {31'd0, irq_a}, 32'd0);
        wr(0, ADDR_MASK, 4'h4);
        chk("unmask_irq", {31'd0, irq_a}, 32'd1);
        wr(0, ADDR_EDGE, 4'hF);
        chk("clrall_irq", {31'd0, irq_a}, 32'd0);
        wr(0, ADDR_MASK, 4'h1);

        // Rising bit0 does not capture for falling type
        in_a = 4'hB;
        step(12);
        chk_reg(0, "rise_nocap", ADDR_EDGE, 4'h0);

        // W1C coincident with a new bit0 edge at edge 7
        in_a = 4'hA;
        step(7);
        wr(0, ADDR_EDGE, 4'h1);
        chk_reg(0, "coinc_cap", ADDR_EDGE, 4'h1);
        chk("coinc_irq", {31'd0, irq_a}, 32'd1);
        wr(0, ADDR_EDGE, 4'h2);
        chk_reg(0, "other_w1c_cap", ADDR_EDGE, 4'h1);
        chk("other_w1c_irq", {31'd0, irq_a}, 32'd1);
        wr(0, ADDR_EDGE, 4'h1);
        chk_reg(0, "final_clr", ADDR_EDGE, 4'h0);

        // Instance B: D=0, any edge; S at edge 2, capture at edge 3
        wr(1, ADDR_MASK, 4'hF);
        in_b = 4'h7;
        step(2);
        chk_reg(1, "b_data_e1", ADDR_DATA, 4'hF);
        step(1);
        chk_reg(1, "b_data_e2", ADDR_DATA, 4'h7);
        chk_reg(1, "b_cap_e2", ADDR_EDGE, 4'h0);
        step(1);
        chk_reg(1, "b_cap_fall", ADDR_EDGE, 4'h8);
        chk("b_irq_fall", {31'd0, irq_b}, 32'd1);
        wr(1, ADDR_EDGE, 4'h8);
        chk("b_irq_clr", {31'd0, irq_b}, 32'd0);
        in_b = 4'hF;
        step(4);
        chk_reg(1, "b_cap_rise", ADDR_EDGE, 4'h8);
        wr(1, ADDR_EDGE, 4'h8);
        in_b = 4'h7;
        step(4);
        chk_reg(1, "b_cap_fall2", ADDR_EDGE, 4'h8);

        // Asynchronous reset between edges
        rst_b = 1'b0;
        chk_reg(1, "b_rst_cap", ADDR_EDGE, 4'h0);
        chk_reg(1, "b_rst_mask", ADDR_MASK, 4'h0);
        chk_reg(1, "b_rst_data", ADDR_DATA, 4'hF);
        chk("b_rst_irq", {31'd0, irq_b}, 32'd0);
        in_b = 4'hF;
        step(1);
        rst_b = 1'b1;
        step(4);
        chk_reg(1, "b_rel_cap", ADDR_EDGE, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
